fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Parametrised instruction-fetch front end for the RV32 datapath: owns the fetch PC, issues in-order
//  requests to instruction memory and buffers returned words with their PCs in a DEPTH-entry queue.
//  Decode pops entries over a valid/ready handshake; a redirect (branch/jump/trap) flushes the queue.
//  Sits between instruction memory and the decode stage of Datapath.
// PARAMETERS
//  XLEN      32            address/PC width
//  DEPTH     4             queue entries; power of two, >= 2
//  RESET_PC  32'h0000_0000 fetch PC after reset
//  PC_STEP   4             PC increment per sequential fetch
// PORTS
//  CLK           in   1                  clock, all state updates on posedge
//  Reset         in   1                  synchronous, active-low reset (0 = reset)
//  Redirect      in   1                  flush queue, restart fetch at RedirectPC
//  RedirectPC    in   XLEN               new fetch PC
//  ImemReqValid  out  1                  fetch request valid
//  ImemReqReady  in   1                  memory accepts request
//  ImemReqAddr   out  XLEN               request address (= fetch PC register)
//  ImemRspValid  in   1                  response word valid; responses in request order, >= 1 cycle later
//  ImemRspData   in   32                 instruction word
//  DecValid      out  1                  head entry holds an instruction
//  DecReady      in   1                  decode accepts head
//  DecInstr      out  32                 head instruction
//  DecPC         out  XLEN               head PC
//  Count         out  $clog2(DEPTH)+1    allocated entries (filled + awaiting response)
// BEHAVIOUR
//  - Reset (Reset==0 at posedge): PC<=RESET_PC; head/alloc/fill pointers, Count, DropCnt <= 0;
//    all entries invalid. ImemReqValid=0 and DecValid=0 while Reset==0.
//  - Slot allocated at issue: issue fires when ImemReqValid & ImemReqReady; slot[alloc].pc<=PC,
//    filled<=0; PC<=PC+PC_STEP (mod 2^XLEN, wraps silently).
//  - ImemReqValid = Reset & ~Redirect & (Count < DEPTH). Full queue (Count==DEPTH) blocks issue.
//  - Response: if DropCnt!=0 -> DropCnt--, word discarded; else slot[fill].instr<=data, filled<=1, fill++.
//  - DecValid = slot[head].filled & (Count!=0). Pop on DecValid & DecReady: head++, Count--.
//  - Issue and pop in the same cycle: Count unchanged. Pointers wrap modulo DEPTH.
//  - Redirect (priority over issue/pop/fill in that cycle): all pointers 0, Count<=0, PC<=RedirectPC,
//    DropCnt <= (requests issued but unanswered, incl. DropCnt) minus 1 if ImemRspValid that cycle.
//    No request issued in the redirect cycle; first request at RedirectPC in the next cycle.
//  - Redirect while DropCnt!=0: counts accumulate; no stale word ever reaches DecInstr.
//  - Outstanding requests never exceed DEPTH + DropCnt; DropCnt width $clog2(2*DEPTH)+1, saturation
//    impossible because issue stalls when Count==DEPTH.
//  - Latency (no bypass): response at cycle N -> DecValid at cycle N+1.
//  - Response with no allocated unfilled slot and DropCnt==0 is a protocol error; simulation $error.
// CONFIGURATION
//  FETCH_QUEUE_BYPASS_EN defined: if head slot is allocated-unfilled, DropCnt==0 and ImemRspValid,
//    DecValid=1 same cycle with DecInstr=ImemRspData, DecPC=slot[head].pc; if DecReady, slot never
//    written as filled (head++, fill++, Count--). Response-to-decode latency 0 cycles.
//  Not defined: no combinational path from ImemRsp* to Dec*; latency 1 cycle as above.
// TESTING
//  1 Reset low 2 cycles, RESET_PC=0 -> ImemReqValid=0, DecValid=0, Count=0; release -> ImemReqAddr=0.
//  2 Ready always 1, 1-cycle rsp, DecReady=1 -> DecPC sequence 0,4,8,C..., one instr/cycle steady.
//  3 DecReady=0, DEPTH=4 -> 4 issues (addr 0..C), Count=4, ImemReqValid=0; DecReady=1 -> resumes at 10.
//  4 3 requests outstanding, Redirect to 0x100 -> DropCnt=3, 3 rsps discarded, first DecPC=0x100.
//  5 Redirect same cycle as rsp and pop -> rsp counted as dropped, Count=0, next ImemReqAddr=RedirectPC.
//  6 FETCH_QUEUE_BYPASS_EN, empty queue, rsp 0x00500093 for PC 0 -> DecValid and DecInstr same cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction-fetch front end. It owns the fetch PC and issues in-order
//   requests to instruction memory. Returned words are buffered, each with its
//   PC, in a DEPTH-entry queue that decode drains over a valid/ready handshake.
//   A redirect flushes the queue and restarts fetch at RedirectPC. Responses
//   to requests that were in flight at the redirect are counted and discarded
//   as they arrive.
//
// Ports
//   CLK           in   1            clock, all state updates on posedge
//   Reset         in   1            synchronous reset, active low
//   Redirect      in   1            flush queue, restart fetch at RedirectPC
//   RedirectPC    in   XLEN         new fetch PC
//   ImemReqValid  out  1            fetch request valid
//   ImemReqReady  in   1            memory accepts the request
//   ImemReqAddr   out  XLEN         request address (the fetch PC register)
//   ImemRspValid  in   1            response word valid, returned in request order
//   ImemRspData   in   32           instruction word
//   DecValid      out  1            head entry holds an instruction
//   DecReady      in   1            decode accepts the head entry
//   DecInstr      out  32           head instruction
//   DecPC         out  XLEN         head PC
//   Count         out  clog2(D)+1   allocated entries (filled + awaiting response)
//
// Build option
//   FETCH_QUEUE_BYPASS_EN  when defined, a response destined for the head slot
//                          is presented to decode in the same cycle. Without it
//                          there is no combinational path from ImemRsp* to Dec*.
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     Redirect,
  input  logic [XLEN-1:0]          RedirectPC,
  output logic                     ImemReqValid,
  input  logic                     ImemReqReady,
  output logic [XLEN-1:0]          ImemReqAddr,
  input  logic                     ImemRspValid,
  input  logic [31:0]              ImemRspData,
  output logic                     DecValid,
  input  logic                     DecReady,
  output logic [31:0]              DecInstr,
  output logic [XLEN-1:0]          DecPC,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(2 * DEPTH) + 1;

  logic [XLEN-1:0]  pc;
  logic [PW-1:0]    head;
  logic [PW-1:0]    alloc;
  logic [PW-1:0]    fill;
  logic [CW-1:0]    count;
  // pend: requests of the current fetch stream still awaiting their word
  logic [CW-1:0]    pend;
  logic [DW-1:0]    drop_cnt;

  logic [XLEN-1:0]  slot_pc    [DEPTH];
  logic [31:0]      slot_instr [DEPTH];
  logic [DEPTH-1:0] slot_filled;

  logic issue;
  logic pop;
  logic rsp_fill;
  logic head_filled;
  logic bypass_pop;

  assign ImemReqValid = Reset & ~Redirect & (count < CW'(DEPTH));
  assign ImemReqAddr  = pc;
  assign issue        = ImemReqValid & ImemReqReady;

  // A response either retires a dropped request or fills the oldest unfilled slot.
  assign rsp_fill     = ImemRspValid & (drop_cnt == '0) & (pend != '0);
  assign head_filled  = slot_filled[head] & (count != '0);
  assign DecPC        = slot_pc[head];
  assign Count        = count;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;

  // Head slot allocated but unfilled means it is the next one the response fills.
  assign bypass     = rsp_fill & (count != '0) & ~slot_filled[head] & (fill == head);
  assign DecValid   = Reset & (head_filled | bypass);
  assign DecInstr   = bypass ? ImemRspData : slot_instr[head];
  assign bypass_pop = bypass & DecReady;
`else
  assign DecValid   = Reset & head_filled;
  assign DecInstr   = slot_instr[head];
  assign bypass_pop = 1'b0;
`endif

  assign pop = DecValid & DecReady;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      pc          <= RESET_PC;
      head        <= '0;
      alloc       <= '0;
      fill        <= '0;
      count       <= '0;
      pend        <= '0;
      drop_cnt    <= '0;
      slot_filled <= '0;
    end else if (Redirect) begin
      pc          <= RedirectPC;
      head        <= '0;
      alloc       <= '0;
      fill        <= '0;
      count       <= '0;
      pend        <= '0;
      slot_filled <= '0;
      // Everything still in flight becomes garbage; a response arriving this
      // cycle already answers one of them.
      drop_cnt    <= drop_cnt + DW'(pend) - DW'(ImemRspValid);
    end else begin
      if (issue) begin
        pc                 <= pc + XLEN'(PC_STEP);
        alloc              <= alloc + PW'(1);
        slot_filled[alloc] <= 1'b0;
      end

      if (ImemRspValid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - DW'(1);
      end else if (rsp_fill) begin
        fill <= fill + PW'(1);
        // A bypassed word goes straight to decode and never occupies the slot.
        if (!bypass_pop) begin
          slot_filled[fill] <= 1'b1;
        end
      end

      if (pop) begin
        head <= head + PW'(1);
      end

      count <= count + CW'(issue) - CW'(pop);
      pend  <= pend + CW'(issue) - CW'(rsp_fill);
    end
  end

  // Slot payloads need no reset; validity lives in slot_filled and count.
  always_ff @(posedge CLK) begin
    if (Reset && !Redirect) begin
      if (issue) begin
        slot_pc[alloc] <= pc;
      end
      if (rsp_fill) begin
        slot_instr[fill] <= ImemRspData;
      end
    end
  end

  a_rsp_protocol: assert property (@(posedge CLK) disable iff (!Reset)
    !(ImemRspValid && (drop_cnt == '0) && (pend == '0)))
    else $error("fetch_queue: response with no outstanding request");

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic             CLK;
  logic             Reset;
  logic             Redirect;
  logic [XLEN-1:0]  RedirectPC;
  logic             ImemReqValid;
  logic             ImemReqReady;
  logic [XLEN-1:0]  ImemReqAddr;
  logic             ImemRspValid;
  logic [31:0]      ImemRspData;
  logic             DecValid;
  logic             DecReady;
  logic [31:0]      DecInstr;
  logic [XLEN-1:0]  DecPC;
  logic [$clog2(DEPTH):0] Count;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .CLK(CLK), .Reset(Reset), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .ImemReqValid(ImemReqValid), .ImemReqReady(ImemReqReady), .ImemReqAddr(ImemReqAddr),
    .ImemRspValid(ImemRspValid), .ImemRspData(ImemRspData),
    .DecValid(DecValid), .DecReady(DecReady), .DecInstr(DecInstr), .DecPC(DecPC),
    .Count(Count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Scoreboard: instructions of the current fetch stream, in program order.
  entry_t      exp_q[$];
  // Memory model: words owed to the DUT, in request order (includes stale ones).
  logic [31:0] mem_q[$];
  logic [31:0] model_pc;
  logic [15:0] serial;

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: observes the handshakes that will fire at the next posedge.
  always @(negedge CLK) begin
    if (!Reset) begin
      exp_q.delete();
      model_pc = 32'h0;
      serial   = 16'h0;
    end else begin
      check("count", 32'(Count), 32'(exp_q.size()));
      check("req_valid", 32'(ImemReqValid), 32'(!Redirect && exp_q.size() < DEPTH));
      if (DecValid && exp_q.size() == 0)
        check("stale_decvalid", 32'(DecValid), 32'h0);
      if (Redirect) begin
        exp_q.delete();
        model_pc = RedirectPC;
      end else begin
        if (DecValid && DecReady && exp_q.size() != 0) begin
          entry_t e;
          e = exp_q.pop_front();
          check("dec_pc", DecPC, e.pc);
          check("dec_instr", DecInstr, e.instr);
        end
        if (ImemReqValid && ImemReqReady) begin
          entry_t n;
          check("req_addr", ImemReqAddr, model_pc);
          n.pc    = model_pc;
          n.instr = {serial, model_pc[17:2]};
          serial  = serial + 16'h1;
          exp_q.push_back(n);
          mem_q.push_back(n.instr);
          model_pc = model_pc + 32'd4;
        end
      end
    end
  end

  task automatic drive(input bit rdy, input bit drdy, input bit redir,
                       input logic [31:0] rpc, input int rsp_pct);
    @(posedge CLK);
    #1;
    ImemReqReady = rdy;
    DecReady     = drdy;
    Redirect     = redir;
    RedirectPC   = rpc;
    if (rsp_pct > 0 && mem_q.size() > 0 && $urandom_range(99) < rsp_pct) begin
      ImemRspValid = 1'b1;
      ImemRspData  = mem_q.pop_front();
    end else begin
      ImemRspValid = 1'b0;
      ImemRspData  = $urandom;
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, 100);
      @(negedge CLK);
      if (mem_q.size() == 0 && Count == 0) done = 1'b1;
    end
    check("drain_count", 32'(Count), 32'h0);
    check("drain_mem_empty", 32'(mem_q.size()), 32'h0);
  endtask

  initial begin
    logic [31:0] lat_data;
    bit found;

    Reset = 1'b0; Redirect = 1'b0; RedirectPC = '0; ImemReqReady = 1'b0;
    ImemRspValid = 1'b0; ImemRspData = '0; DecReady = 1'b0;

    // Reset held for two cycles
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_req_valid", 32'(ImemReqValid), 32'h0);
    check("rst_dec_valid", 32'(DecValid), 32'h0);
    check("rst_count", 32'(Count), 32'h0);
    @(posedge CLK);
    #1 Reset = 1'b1;
    @(negedge CLK);
    check("rel_req_valid", 32'(ImemReqValid), 32'h1);
    check("rel_req_addr", ImemReqAddr, 32'h0);

    // Decode stalled: queue fills to DEPTH and issue stops
    repeat (8) drive(1'b1, 1'b0, 1'b0, 32'h0, 100);
    @(negedge CLK);
    check("full_count", 32'(Count), 32'(DEPTH));
    check("full_req_valid", 32'(ImemReqValid), 32'h0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, 100);
      @(negedge CLK);
      if (ImemReqValid) found = 1'b1;
    end
    check("resume_found", 32'(found), 32'h1);
    check("resume_addr", ImemReqAddr, 32'h10);

    // Steady stream: one instruction per cycle
    repeat (6) drive(1'b1, 1'b1, 1'b0, 32'h0, 100);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, 100);
      @(negedge CLK);
      check("steady_dec_valid", 32'(DecValid), 32'h1);
    end

    // Response-to-decode latency on an empty queue
    drain();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 0);
    lat_data = (mem_q.size() != 0) ? mem_q[0] : 32'h0;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 100);
    @(negedge CLK);
`ifdef FETCH_QUEUE_BYPASS_EN
    check("lat0_dec_valid", 32'(DecValid), 32'h1);
    check("lat0_dec_instr", DecInstr, lat_data);
`else
    check("lat0_dec_valid", 32'(DecValid), 32'h0);
`endif
    drive(1'b0, 1'b1, 1'b0, 32'h0, 0);
    @(negedge CLK);
`ifdef FETCH_QUEUE_BYPASS_EN
    check("lat1_dec_valid", 32'(DecValid), 32'h0);
`else
    check("lat1_dec_valid", 32'(DecValid), 32'h1);
    check("lat1_dec_instr", DecInstr, lat_data);
`endif

    // Redirect with three requests outstanding
    drain();
    repeat (3) drive(1'b1, 1'b1, 1'b0, 32'h0, 0);
    drive(1'b0, 1'b1, 1'b1, 32'h100, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, 100);
      @(negedge CLK);
      if (DecValid && DecReady) found = 1'b1;
    end
    check("redir_pop_found", 32'(found), 32'h1);
    check("redir_first_pc", DecPC, 32'h100);

    // Redirect in the same cycle as a response and a pop
    drain();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 100);
    drive(1'b0, 1'b1, 1'b1, 32'h200, 100);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 0);
    @(negedge CLK);
    check("coll_count", 32'(Count), 32'h0);
    check("coll_req_addr", ImemReqAddr, 32'h200);
    check("coll_dec_valid", 32'(DecValid), 32'h0);
    repeat (10) drive(1'b1, 1'b1, 1'b0, 32'h0, 100);

    // Random traffic against the scoreboard
    for (int i = 0; i < 3000; i++) begin
      bit          redir;
      logic [31:0] rpc;
      redir = ($urandom_range(99) < 3) && (mem_q.size() <= DEPTH);
      case ($urandom_range(2))
        0:       rpc = 32'hFFFF_FFF8;
        1:       rpc = 32'h0;
        default: rpc = $urandom & 32'hFFFF_FFFC;
      endcase
      drive(1'($urandom_range(1)), 1'($urandom_range(1)), redir, rpc, 60);
    end

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
